// File: rtl/voter_pkg.sv
// Shared encodings for the majority voter: channel health states and counter sizing.
package voter_pkg;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_SUSPECT = 2'd1,
    ST_FAILED  = 2'd2
  } health_e;

  // Bits needed to hold values 0..n inclusive.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/majority_voter_chan_health.sv
// Per-channel health tracker: OK -> SUSPECT -> FAILED after FAIL_THRESH consecutive disagreements.
// Updates only on accepted transfers; clear wins over any same-cycle transition. VOTER_STATS_EN adds a saturating counter.
module chan_health
  import voter_pkg::*;
#(
  parameter int FAIL_THRESH = 4
`ifdef VOTER_STATS_EN
  , parameter int STAT_W = 16
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic upd,
  input  logic disagree,
  input  logic clear,
  output logic failed
`ifdef VOTER_STATS_EN
  , output logic [STAT_W-1:0] mismatch_cnt
`endif
);

  localparam int CW = cnt_w(FAIL_THRESH);

  health_e       state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          failed_q, failed_d;

  assign failed = failed_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (upd) begin
      case (state_q)
        ST_OK: begin
          if (disagree) begin
            state_d = (FAIL_THRESH == 1) ? ST_FAILED : ST_SUSPECT;
            cnt_d   = CW'(1);
          end
        end
        ST_SUSPECT: begin
          if (disagree) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_d == CW'(FAIL_THRESH)) state_d = ST_FAILED;
          end else begin
            state_d = ST_OK;
            cnt_d   = '0;
          end
        end
        default: ;
      endcase
    end
    if (clear) begin
      state_d = ST_OK;
      cnt_d   = '0;
    end
    failed_d = (state_d == ST_FAILED);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_OK;
      cnt_q    <= '0;
      failed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      failed_q <= failed_d;
    end
  end

`ifdef VOTER_STATS_EN
  logic [STAT_W-1:0] stat_q, stat_d;

  assign mismatch_cnt = stat_q;

  // FAILED channels are no longer compared, so they stop accumulating.
  always_comb begin
    stat_d = stat_q;
    if (upd && disagree && (state_q != ST_FAILED) && (stat_q != '1))
      stat_d = stat_q + STAT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) stat_q <= '0;
    else        stat_q <= stat_d;
  end
`endif

endmodule

// File: rtl/majority_voter.sv
// Registered N_CH-input bitwise majority voter, latency 1 clk; in_ready = ~out_valid | out_ready.
// FAILED channels are excluded from the vote; VOTER_STATS_EN adds per-channel mismatch_cnt.
module majority_voter
  import voter_pkg::*;
#(
  parameter int              N_CH        = 3,
  parameter int              WIDTH       = 1,
  parameter logic [N_CH-1:0] INV_MASK    = 'b001,
  parameter int              FAIL_THRESH = 4
`ifdef VOTER_STATS_EN
  , parameter int            STAT_W      = 16
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic [N_CH-1:0]       clear_fault,
  output logic [N_CH-1:0]       ch_failed,
  output logic                  all_failed
`ifdef VOTER_STATS_EN
  , output logic [N_CH*STAT_W-1:0] mismatch_cnt
`endif
);

  localparam int AW = cnt_w(N_CH);

  logic [N_CH*WIDTH-1:0] corr;
  logic [N_CH-1:0]       active, disagree;
  logic [AW-1:0]         n_active, ones;
  logic [WIDTH-1:0]      vote;
  logic                  accept, pop;
  logic                  out_valid_q, out_valid_d;
  logic [WIDTH-1:0]      out_data_q, out_data_d;

  assign in_ready   = ~out_valid_q | out_ready;
  assign accept     = in_valid & in_ready;
  assign pop        = out_valid_q & out_ready;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign active     = ~ch_failed;
  assign all_failed = &ch_failed;

  // Strict majority of the active set: 2*ones > n_active, so ties and an empty set give 0.
  always_comb begin
    corr     = '0;
    n_active = '0;
    ones     = '0;
    vote     = '0;
    disagree = '0;
    for (int i = 0; i < N_CH; i++) begin
      corr[i*WIDTH +: WIDTH] = in_data[i*WIDTH +: WIDTH] ^ {WIDTH{INV_MASK[i]}};
      n_active = n_active + AW'(active[i]);
    end
    for (int b = 0; b < WIDTH; b++) begin
      ones = '0;
      for (int i = 0; i < N_CH; i++)
        ones = ones + AW'(active[i] & corr[i*WIDTH + b]);
      vote[b] = ({ones, 1'b0} > {1'b0, n_active});
    end
    for (int i = 0; i < N_CH; i++)
      disagree[i] = (corr[i*WIDTH +: WIDTH] != vote);
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (pop) out_valid_d = 1'b0;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = vote;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    chan_health #(
      .FAIL_THRESH(FAIL_THRESH)
`ifdef VOTER_STATS_EN
      , .STAT_W(STAT_W)
`endif
    ) u_health (
      .clk      (clk),
      .rst_n    (rst_n),
      .upd      (accept),
      .disagree (disagree[i]),
      .clear    (clear_fault[i]),
      .failed   (ch_failed[i])
`ifdef VOTER_STATS_EN
      , .mismatch_cnt(mismatch_cnt[i*STAT_W +: STAT_W])
`endif
    );
  end

endmodule
